// File: rtl/lru_array.sv
// Per-set pseudo-LRU word storage for the 4-way cache: one LRU_W-bit word per set,
// cleared by a one-set-per-cycle sweep after reset, read with one cycle of latency.
module lru_array #(
  parameter int                SET_IDX_W = 4,
  parameter int                LRU_W     = 3,
  parameter logic [LRU_W-1:0]  INIT_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 rd_en,
  input  logic [SET_IDX_W-1:0] rd_set,
  output logic                 rvalid,
  output logic [LRU_W-1:0]     rdata,
  input  logic                 wr_en,
  input  logic [SET_IDX_W-1:0] wr_set,
  input  logic [LRU_W-1:0]     wr_data,
  output logic                 dbg_state
);

  localparam int                   NUM_SETS = 1 << SET_IDX_W;
  localparam logic [SET_IDX_W-1:0] LAST_SET = SET_IDX_W'(NUM_SETS - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SET_IDX_W-1:0] sweep_cnt;
  logic [LRU_W-1:0]     mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (sweep_cnt == LAST_SET) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // Terminal compare: the counter parks on the last set instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                                        sweep_cnt <= '0;
    else if (state == ST_INIT && sweep_cnt != LAST_SET) sweep_cnt <= sweep_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) mem[sweep_cnt] <= INIT_VAL;
      else if (wr_en)       mem[wr_set]    <= wr_data;
    end
  end

  // Write-first bypass: a same-edge write to the set being read wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (state == ST_READY && rd_en) begin
      rvalid <= 1'b1;
      rdata  <= (wr_en && wr_set == rd_set) ? wr_data : mem[rd_set];
    end else begin
      rvalid <= 1'b0;
    end
  end

  assign ready     = (state == ST_READY);
  assign dbg_state = state;

endmodule
